// File: rtl/mac_col_issuer.sv
// Initiator for the mac_col column chain: streams kernel then query vectors from a
// 1-cycle SRAM onto q_out/o_inst. Optional abort input enabled by MAC_ISSUER_ABORT_EN.
module mac_col_issuer #(
  parameter int bw        = 8,
  parameter int pr        = 8,
  parameter int addr_w    = 8,
  parameter int flush_cyc = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [addr_w-1:0]    k_base,
  input  logic [addr_w-1:0]    k_len,
  input  logic [addr_w-1:0]    q_base,
  input  logic [addr_w-1:0]    q_len,
`ifdef MAC_ISSUER_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 mem_rd_en,
  output logic [addr_w-1:0]    mem_addr,
  input  logic [bw*pr-1:0]     mem_rdata,
  output logic [bw*pr-1:0]     q_out,
  output logic [1:0]           o_inst,
  output logic                 busy,
  output logic                 done
);

  localparam int FW = $clog2(flush_cyc + 3);
  localparam int CW = (addr_w > FW) ? addr_w : FW;
  localparam logic [CW-1:0] FLUSH_LEN = CW'(flush_cyc + 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_LOAD = 2'b01;
  localparam logic [1:0] T_EXEC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_EXEC, S_FLUSH, S_DONE
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [addr_w-1:0]   q_base_r;
  logic [addr_w-1:0]   q_len_r;
  logic [1:0]          tag_p0;
  logic [1:0]          tag_p1;
  logic                abort_req;

`ifdef MAC_ISSUER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      q_base_r  <= '0;
      q_len_r   <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      tag_p0    <= T_IDLE;
      tag_p1    <= T_IDLE;
      o_inst    <= T_IDLE;
      q_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Stage p0 -> p1: the read issued this cycle returns data next cycle
      tag_p1 <= tag_p0;
      // Stage p1 -> output: register returned data with its tag; idle slots hold q_out
      o_inst <= tag_p1;
      if (tag_p1 != T_IDLE) q_out <= mem_rdata;

      case (state)
        S_IDLE: begin
          if (start) begin
            q_base_r <= q_base;
            q_len_r  <= q_len;
            busy     <= 1'b1;
            if (k_len != '0) begin
              state     <= S_LOAD;
              mem_rd_en <= 1'b1;
              mem_addr  <= k_base;
              cnt       <= CW'(k_len);
              tag_p0    <= T_LOAD;
            end else if (q_len != '0) begin
              state     <= S_EXEC;
              mem_rd_en <= 1'b1;
              mem_addr  <= q_base;
              cnt       <= CW'(q_len);
              tag_p0    <= T_EXEC;
            end else begin
              state <= S_FLUSH;
              cnt   <= FLUSH_LEN;
            end
          end
        end

        S_LOAD: begin
          if (abort_req) begin
            state     <= S_FLUSH;
            mem_rd_en <= 1'b0;
            tag_p0    <= T_IDLE;
            cnt       <= FLUSH_LEN;
          end else if (cnt == CNT_ONE) begin
            state     <= S_GAP;
            mem_rd_en <= 1'b0;
            tag_p0    <= T_IDLE;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt - 1'b1;
          end
        end

        // One bubble between kernel and query words so the column sees a clean switch
        S_GAP: begin
          if (abort_req || q_len_r == '0) begin
            state <= S_FLUSH;
            cnt   <= FLUSH_LEN;
          end else begin
            state     <= S_EXEC;
            mem_rd_en <= 1'b1;
            mem_addr  <= q_base_r;
            cnt       <= CW'(q_len_r);
            tag_p0    <= T_EXEC;
          end
        end

        S_EXEC: begin
          if (abort_req || cnt == CNT_ONE) begin
            state     <= S_FLUSH;
            mem_rd_en <= 1'b0;
            tag_p0    <= T_IDLE;
            cnt       <= FLUSH_LEN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt - 1'b1;
          end
        end

        S_FLUSH: begin
          if (cnt == CNT_ONE) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
